// File: rtl/code_seq_checker.sv
// code_seq_checker: verifies a mode-tagged 4-bit code stream follows its successor rule, with lock hysteresis and error counting.
module code_seq_checker #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [3:0]       code,
  output logic             locked,
  output logic             err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       exp_code
);
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  localparam logic [MW-1:0] LOCK_M1 = MW'(LOCK_N - 1);
  localparam logic [LW-1:0] LOSS_M1 = LW'(LOSS_N - 1);
  state_t state, nxt_state;
  logic [MW-1:0] match_cnt, nxt_match;
  logic [LW-1:0] miss_cnt, nxt_miss;
  logic [3:0] ref_code, nxt_ref, succ_ref, nxt_exp;
  logic last_mode, nxt_mode, nxt_err, nxt_illegal, nxt_ready, acc, bad, resync, hit;

  function automatic logic [3:0] succ(input logic [3:0] x, input logic m);
    return m ? x + 4'd1 : (x == 4'd0 ? 4'd9 : x - 4'd1);
  endfunction

  always_comb begin
    acc = in_valid && in_ready;
    bad = !mode && code > 4'd9;
    resync = acc && mode != last_mode && state != IDLE && !bad;
    succ_ref = succ(ref_code, mode);
    hit = code == succ_ref && !bad;
    nxt_state = state;
    nxt_match = match_cnt;
    nxt_miss = miss_cnt;
    nxt_ref = ref_code;
    nxt_mode = acc ? mode : last_mode;
    nxt_err = 1'b0;
    nxt_illegal = acc && bad;
    nxt_ready = 1'b1;
    if (resync) begin
      nxt_state = HUNT;
      nxt_ref = code;
      nxt_match = MW'(1);
      nxt_miss = '0;
      nxt_ready = 1'b0;
    end else if (acc && state == LOCKED) begin
      if (hit) begin
        nxt_ref = code;
        nxt_miss = '0;
      end else begin
        // flywheel: advance the reference as if the expected word had arrived
        nxt_err = 1'b1;
        nxt_ref = succ_ref;
        nxt_miss = miss_cnt == LOSS_M1 ? '0 : miss_cnt + LW'(1);
        nxt_state = miss_cnt == LOSS_M1 ? IDLE : LOCKED;
      end
    end else if (acc && bad) begin
      nxt_state = IDLE;
      nxt_match = '0;
    end else if (acc && (state == IDLE || !hit)) begin
      nxt_ref = code;
      nxt_match = MW'(1);
      nxt_state = (state == IDLE && LOCK_N == 1) ? LOCKED : HUNT;
    end else if (acc) begin
      nxt_ref = code;
      nxt_match = match_cnt + MW'(1);
      nxt_state = match_cnt >= LOCK_M1 ? LOCKED : HUNT;
    end
    nxt_exp = nxt_state == IDLE ? 4'd0 : succ(nxt_ref, nxt_mode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      match_cnt <= '0;
      miss_cnt <= '0;
      ref_code <= '0;
      last_mode <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
      illegal <= 1'b0;
      err_count <= '0;
      exp_code <= '0;
      in_ready <= 1'b0;
    end else begin
      state <= nxt_state;
      match_cnt <= nxt_match;
      miss_cnt <= nxt_miss;
      ref_code <= nxt_ref;
      last_mode <= nxt_mode;
      locked <= nxt_state == LOCKED;
      err <= nxt_err;
      illegal <= nxt_illegal;
      err_count <= (nxt_err && err_count != '1) ? err_count + ERR_W'(1) : err_count;
      exp_code <= nxt_exp;
      in_ready <= nxt_ready;
    end
  end
endmodule

// File: tb/tb_code_seq_checker.sv
// tb_code_seq_checker: random and directed stimulus against a rule-level model, for default and saturation-heavy configurations.
module tb_code_seq_checker;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0;
  logic [3:0] code = 4'd0;
  logic a_ready, a_locked, a_err, a_ill, b_ready, b_locked, b_err, b_ill;
  logic [7:0] a_errc;
  logic [1:0] b_errc;
  logic [3:0] a_exp, b_exp;
  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  code_seq_checker u_a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .mode(mode),
    .code(code), .locked(a_locked), .err(a_err), .illegal(a_ill), .err_count(a_errc), .exp_code(a_exp));
  code_seq_checker #(.LOCK_N(4), .LOSS_N(8), .ERR_W(2)) u_b (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(b_ready), .mode(mode), .code(code), .locked(b_locked), .err(b_err), .illegal(b_ill),
    .err_count(b_errc), .exp_code(b_exp));

  typedef struct {
    int st, match, miss, refv, lm, errc, ready, err, ill, exp, locked;
  } mdl_t;
  mdl_t ma, mb;

  function automatic int succ(int x, int m);
    return m != 0 ? (x + 1) % 16 : (x == 0 ? 9 : x - 1);
  endfunction

  function automatic mdl_t mreset();
    mdl_t z = '{default: 0};
    return z;
  endfunction

  // st: 0 = idle, 1 = hunting, 2 = locked
  function automatic mdl_t mstep(mdl_t s, int v, int m, int c, int lock_n, int loss_n, int emax);
    mdl_t n = s;
    int want = succ(s.refv, m);
    bit legal = m != 0 || c <= 9;
    n.err = 0; n.ill = 0; n.ready = 1;
    if (v != 0 && s.ready != 0) begin
      n.ill = !legal;
      n.lm = m;
      if (s.st != 0 && m != s.lm && legal) begin
        n.st = 1; n.refv = c; n.match = 1; n.miss = 0; n.ready = 0;
      end else if (s.st == 2) begin
        if (legal && c == want) begin
          n.refv = c; n.miss = 0;
        end else begin
          n.err = 1; n.errc = s.errc < emax ? s.errc + 1 : emax;
          n.refv = want; n.miss = s.miss + 1;
          if (n.miss >= loss_n) begin n.st = 0; n.miss = 0; end
        end
      end else if (!legal) begin
        n.st = 0; n.match = 0;
      end else if (s.st == 1 && c == want) begin
        n.refv = c; n.match = s.match + 1;
        if (n.match >= lock_n) n.st = 2;
      end else begin
        n.refv = c; n.match = 1;
        n.st = (s.st == 0 && lock_n == 1) ? 2 : 1;
      end
    end
    n.exp = n.st == 0 ? 0 : succ(n.refv, n.lm);
    n.locked = n.st == 2 ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, int'(in_valid), int'(mode), int'(code), 4, 3, 255);
      mb <= mstep(mb, int'(in_valid), int'(mode), int'(code), 4, 8, 3);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ready", int'(a_ready), ma.ready);
    chk("a_locked", int'(a_locked), ma.locked);
    chk("a_err", int'(a_err), ma.err);
    chk("a_illegal", int'(a_ill), ma.ill);
    chk("a_err_count", int'(a_errc), ma.errc);
    chk("a_exp_code", int'(a_exp), ma.exp);
    chk("b_ready", int'(b_ready), mb.ready);
    chk("b_locked", int'(b_locked), mb.locked);
    chk("b_err", int'(b_err), mb.err);
    chk("b_illegal", int'(b_ill), mb.ill);
    chk("b_err_count", int'(b_errc), mb.errc);
    chk("b_exp_code", int'(b_exp), mb.exp);
  end

  task automatic drv(input int v, input int m, input int c);
    @(negedge clk);
    in_valid = v[0]; mode = m[0]; code = c[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", int'(a_ready), 0);
    chk("rst_exp", int'(a_exp), 0);
    // binary lock
    for (int i = 0; i < 4; i++) drv(1, 1, i);
    chk("t1_locked", int'(a_locked), 1);
    chk("t1_exp", int'(a_exp), 4);
    chk("t1_model_exp", ma.exp, 4);
    chk("t1_errc", int'(a_errc), 0);
    // flywheel through one error
    drv(1, 1, 7);
    chk("t2_err", int'(a_err), 1);
    chk("t2_errc", int'(a_errc), 1);
    chk("t2_exp", int'(a_exp), 5);
    drv(1, 1, 5);
    chk("t2_err_clear", int'(a_err), 0);
    chk("t2_exp2", int'(a_exp), 6);
    chk("t2_locked", int'(a_locked), 1);
    // loss of lock
    do_reset();
    for (int i = 0; i < 4; i++) drv(1, 1, i);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 9);
      chk("t3_err", int'(a_err), 1);
    end
    chk("t3_errc", int'(a_errc), 3);
    chk("t3_locked", int'(a_locked), 0);
    chk("t3_exp", int'(a_exp), 0);
    chk("t3_model_errc", ma.errc, 3);
    // BCD with wrap and an illegal word
    do_reset();
    drv(1, 0, 2); drv(1, 0, 1); drv(1, 0, 0); drv(1, 0, 9);
    chk("t4_locked", int'(a_locked), 1);
    chk("t4_exp", int'(a_exp), 8);
    drv(1, 0, 12);
    chk("t4_illegal", int'(a_ill), 1);
    chk("t4_err", int'(a_err), 1);
    chk("t4_exp2", int'(a_exp), 7);
    // mode flip while locked
    do_reset();
    for (int i = 2; i < 6; i++) drv(1, 1, i);
    chk("t5_pre_locked", int'(a_locked), 1);
    drv(1, 0, 3);
    chk("t5_locked", int'(a_locked), 0);
    chk("t5_err", int'(a_err), 0);
    chk("t5_ready", int'(a_ready), 0);
    chk("t5_exp", int'(a_exp), 2);
    drv(0, 0, 0);
    chk("t5_ready_back", int'(a_ready), 1);
    // saturation on the narrow counter, then asynchronous reset
    do_reset();
    for (int i = 0; i < 4; i++) drv(1, 1, i);
    for (int i = 0; i < 5; i++) drv(1, 1, 9);
    chk("t6_errc_sat", int'(b_errc), 3);
    chk("t6_model_sat", mb.errc, 3);
    chk("t6_locked", int'(b_locked), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_locked", int'(b_locked), 0);
    chk("t6_rst_errc", int'(b_errc), 0);
    chk("t6_rst_exp", int'(b_exp), 0);
    chk("t6_rst_ready", int'(b_ready), 0);
    chk("t6_rst_err", int'(b_err), 0);
    chk("t6_rst_a_errc", int'(a_errc), 0);
    @(negedge clk);
    rst = 1'b0;
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      in_valid = $urandom_range(0, 9) < 8;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      code = $urandom_range(0, 9) < 6 ? 4'(ma.exp) : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/code_seq_checker.md
Name: code_seq_checker

Overview:
- Receiver-side checker for the 4-bit mode-selectable code sequence produced by the team's next-code logic.
- Accepts a stream of 4-bit code words tagged with a mode bit and checks that each word is the legal successor of the previous one.
- Acquires and loses lock with hysteresis, flywheels through isolated errors, and counts sequence errors.
- Sits downstream of the code generator as its link-integrity monitor.

Parameters:
LOCK_N, 4, consecutive in-sequence words needed to declare lock (>=1)
LOSS_N, 3, consecutive mismatches in LOCKED that drop lock (>=1)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  code word present
in_ready  output  1  checker can accept a word
mode  input  1  1 = binary up-count sequence, 0 = BCD down-count sequence
code  input  4  code word
locked  output  1  sequence lock achieved
err  output  1  one-cycle pulse: sequence error while locked
illegal  output  1  one-cycle pulse: word not a valid code for its mode
err_count  output  ERR_W  saturating count of err pulses
exp_code  output  4  next expected code word

Behaviour:
- Reset (async, active-high) forces:
  - locked=0, err=0, illegal=0, err_count=0, exp_code=0, in_ready=0.
  - State IDLE, match_cnt=0, miss_cnt=0, ref=0, last_mode=0.
- in_ready is 0 while rst is high. It rises on the first clk edge after rst deasserts.
- A word is accepted on a rising edge where in_valid && in_ready. Non-accepted cycles change no state, and err/illegal return to 0.
- All outputs are registered. Results of a word accepted at edge k are visible after edge k (1-cycle latency).
- Successor rule succ(x,m):
  - m=1: (x+1) mod 16, so 15->0.
  - m=0: x-1 for 1..9, 0->9. Codes 10..15 are illegal in m=0.
- Illegal word (m=0, code>9): illegal=1 for one cycle. The word is never stored as ref.
  - In LOCKED it counts as a mismatch.
  - Elsewhere: state->IDLE, match_cnt=0.
- Mode change: an accepted word whose mode differs from last_mode while state!=IDLE is a resync, not an error.
  - state->HUNT, ref=word, match_cnt=1, miss_cnt=0, locked=0, no err pulse.
  - in_ready=0 for exactly the next cycle.
  - last_mode updates on every accepted word.
- IDLE: first legal accepted word -> ref=word, match_cnt=1. Go to HUNT, or to LOCKED if LOCK_N==1.
- HUNT:
  - word==succ(ref,mode): ref=word, match_cnt+1. Reaching LOCK_N -> LOCKED with locked=1.
  - Legal mismatch: ref=word, match_cnt=1, stay HUNT.
  - No err pulses in HUNT.
- LOCKED:
  - Match: ref=word, miss_cnt=0.
  - Mismatch (including illegal): err=1, err_count+1 saturating at 2^ERR_W-1, miss_cnt+1, ref=succ(ref,mode) (flywheel).
  - When miss_cnt reaches LOSS_N: state->IDLE, locked=0, miss_cnt=0, exp_code=0. err still pulses for that word.
- exp_code = succ(ref,last_mode) whenever state!=IDLE, else 0.
- err_count is never cleared except by rst.
- Reset mid-stream takes effect immediately, regardless of state or in-flight word.

Test Plan:
1. Lock in binary mode: mode=1, accept 0,1,2,3 back-to-back -> locked=1 after 4th word, exp_code=4, err_count=0.
2. Flywheel error: locked at 3, send 7 then 5 -> err=1 once, err_count=1, exp_code=5 then 6, locked stays 1.
3. Loss of lock: locked at 3, send 9,9,9 -> err pulses 3 times, err_count=3, locked=0 after 3rd word, exp_code=0.
4. BCD mode with wrap and illegal word: mode=0, send 2,1,0,9 -> locked=1, exp_code=8; send 12 -> illegal=1, err=1, exp_code=7.
5. Mode flip while locked: binary locked at 5, send code=3 with mode=0 -> locked=0, no err, in_ready=0 for one cycle, exp_code=2.
6. Saturation and async reset: ERR_W=2, locked, LOSS_N=8, 5 mismatches -> err_count=3; assert rst mid-cycle -> all outputs 0 without a clock edge.
